// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: 4x4 keypad column scanner with whole-scan debounce and a key-code FIFO.
module kypd_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_EVAL   = 2'd2;

  // Key state encoding: {is_key, code}; all-zero means no key.
  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  logic [1:0]       state_q, state_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      press_q, press_d;
  logic [4:0]       cand_q, cand_d;
  logic [4:0]       commit_q, commit_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             held_q, held_d;
  logic             push;
  logic [3:0]       push_code;

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [3:0]       head_q, head_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, accept;

  logic [4:0]       hits;
  logic [4:0]       scan_res;
  logic             scan_multi;

  // Key map indexed by {column, row}.
  function automatic logic [3:0] key_lut(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h4;
      4'd2:  code = 4'h7;
      4'd3:  code = 4'h0;
      4'd4:  code = 4'h2;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h8;
      4'd7:  code = 4'hF;
      4'd8:  code = 4'h3;
      4'd9:  code = 4'h6;
      4'd10: code = 4'h9;
      4'd11: code = 4'hE;
      4'd12: code = 4'hA;
      4'd13: code = 4'hB;
      4'd14: code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Reduce the full-scan press map to none / single code / multiple.
  always_comb begin
    hits     = 5'd0;
    scan_res = KEY_NONE;
    for (int i = 0; i < 16; i++) begin
      if (press_q[i]) begin
        hits     = hits + 5'd1;
        scan_res = {1'b1, key_lut(4'(i))};
      end
    end
    scan_multi = (hits >= 5'd2);
  end

  // Scan FSM next state, row capture and debounce/commit decision.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    col_idx_d    = col_idx_q;
    col_d        = col_q;
    press_d      = press_q;
    cand_d       = cand_q;
    commit_d     = commit_q;
    db_cnt_d     = db_cnt_q;
    held_d       = held_q;
    push         = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = ST_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        press_d[{col_idx_q, 2'b00} +: 4] = ~row;
        col_idx_d = col_idx_q + 2'd1;
        col_d     = {col_q[2:0], col_q[3]};
        state_d   = (col_idx_q == 2'd3) ? ST_EVAL : ST_SETTLE;
      end
      ST_EVAL: begin
        state_d = ST_SETTLE;
        if (scan_multi) begin
          db_cnt_d = '0;
        end else if (scan_res == cand_q) begin
          if (db_cnt_q != DB_W'(DEBOUNCE_SCANS)) db_cnt_d = db_cnt_q + DB_W'(1);
        end else begin
          cand_d   = scan_res;
          db_cnt_d = DB_W'(1);
        end
        if (!scan_multi && (db_cnt_d == DB_W'(DEBOUNCE_SCANS)) && (cand_d != commit_q)) begin
          commit_d = cand_d;
          push     = cand_d[4];
        end
        held_d = commit_d[4];
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  assign push_code = cand_d[3:0];

  // FIFO pointer/occupancy update and next head value.
  always_comb begin
    pop        = valid_q & key_ready;
    full       = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    accept     = push & (~full | pop);
    ovf_d      = ovf_q | (push & full & ~pop);
    wr_ptr_d   = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(accept) - CNT_W'(pop);
    valid_d    = (fifo_cnt_d != '0);
    if (fifo_cnt_d == '0) begin
      head_d = 4'h0;
    end else if (accept && (wr_ptr_q == rd_ptr_d)) begin
      head_d = push_code;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Scan and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      col_idx_q    <= 2'd0;
      col_q        <= 4'b1110;
      press_q      <= '0;
      cand_q       <= KEY_NONE;
      commit_q     <= KEY_NONE;
      db_cnt_q     <= '0;
      held_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      press_q      <= press_d;
      cand_q       <= cand_d;
      commit_q     <= commit_d;
      db_cnt_q     <= db_cnt_d;
      held_q       <= held_d;
    end
  end

  // FIFO storage and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      head_q     <= 4'h0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) mem_q[wr_ptr_q] <= push_code;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign col       = col_q;
  assign key_code  = head_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// tb_kypd_scan_ctrl: scan-level reference model of keypad debounce and key FIFO.
module tb_kypd_scan_ctrl;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned DEB    = 2;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PERIOD = 4 * (SETTLE + 1) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready = 1'b0;
  logic        key_held;
  logic        overflow;
  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;

  // Reference model state: -1 stands for "no key".
  int         m_cand = -1;
  int         m_cnt  = 0;
  int         m_comm = -1;
  bit         m_ovf  = 1'b0;
  logic [3:0] exp_q [$];

  logic [3:0] keymap [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                              4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE,
                              4'hA, 4'hB, 4'hC, 4'hD};

  always #5 clk = ~clk;

  kypd_scan_ctrl #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overflow (overflow)
  );

  // Ideal keypad: a row reads low if a pressed key on it sits in a driven-low column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col[c] && pressed[c*4 + r]) row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mask_of(input logic [3:0] code);
    logic [15:0] m = 16'h0;
    for (int i = 0; i < 16; i++)
      if (keymap[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  // One full scan worth of debounce rules applied to the set of held keys.
  task automatic model_scan(input logic [15:0] m);
    int n = $countones(m);
    int res = -1;
    if (n >= 2) begin
      m_cnt = 0;
    end else begin
      for (int i = 0; i < 16; i++)
        if (m[i]) res = int'(keymap[i]);
      if (res == m_cand) begin
        if (m_cnt < DEB) m_cnt++;
      end else begin
        m_cand = res;
        m_cnt  = 1;
      end
      if (m_cnt == DEB && m_cand != m_comm) begin
        m_comm = m_cand;
        if (m_comm >= 0) begin
          if (exp_q.size() == DEPTH) m_ovf = 1'b1;
          else exp_q.push_back(4'(m_comm));
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_held"}, key_held, (m_comm >= 0));
    check({tag, "_ovf"}, overflow, m_ovf);
    check({tag, "_valid"}, key_valid, (exp_q.size() != 0));
    check({tag, "_code"}, key_code, (exp_q.size() != 0) ? exp_q[0] : 4'h0);
  endtask

  // Hold a key set for one scan; pops are checked against the model as they occur.
  task automatic run_scan(input logic [15:0] m, input logic rdy, input string tag);
    pressed   = m;
    key_ready = rdy;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (key_ready) begin
        check({tag, "_pop_valid"}, key_valid, (exp_q.size() != 0));
        if (key_valid && exp_q.size() != 0) begin
          check({tag, "_pop_code"}, key_code, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
    end
    #1;
    model_scan(m);
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    rst       = 1'b1;
    key_ready = 1'b0;
    pressed   = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_col"}, col, 4'b1110);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_held"}, key_held, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_code"}, key_code, 4'h0);
    rst     = 1'b0;
    pressed = 16'h0;
    m_cand  = -1;
    m_cnt   = 0;
    m_comm  = -1;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] rm;
    int          hold, a, b, kind;

    // Reset and column-advance timing.
    do_reset("rst");
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("rst_col_step", col, (k < 3) ? 4'b1110 : 4'b1101);
    end
    repeat (PERIOD - 3) @(posedge clk);
    #1;
    model_scan(16'h0);
    check_state("rst_scan0");

    // Clean press of '5', release, then drain.
    for (int s = 0; s < 4; s++) run_scan(mask_of(4'h5), 1'b0, "press5");
    for (int s = 0; s < 3; s++) run_scan(16'h0, 1'b0, "rel5");
    run_scan(16'h0, 1'b1, "drain5");

    // Bouncing '9' never commits.
    for (int s = 0; s < 4; s++) begin
      run_scan(mask_of(4'h9), 1'b0, "bounce_on");
      run_scan(16'h0, 1'b0, "bounce_off");
    end

    // Two keys together, then '1' alone.
    for (int s = 0; s < 5; s++) run_scan(mask_of(4'h1) | mask_of(4'hA), 1'b0, "multi");
    for (int s = 0; s < 2; s++) run_scan(mask_of(4'h1), 1'b0, "single1");
    for (int s = 0; s < 2; s++) run_scan(16'h0, 1'b0, "rel1");
    run_scan(16'h0, 1'b1, "drain1");

    // Five presses into a four-deep queue, then drain in order.
    for (int k = 1; k <= 5; k++) begin
      for (int s = 0; s < 2; s++) run_scan(mask_of(4'(k)), 1'b0, "ovf_press");
      for (int s = 0; s < 2; s++) run_scan(16'h0, 1'b0, "ovf_rel");
    end
    check("ovf_set", overflow, 1'b1);
    run_scan(16'h0, 1'b1, "ovf_drain");
    check("ovf_empty", key_valid, 1'b0);

    // Direct roll-over B -> C, then reset mid-settle discards a queued key.
    do_reset("rst2");
    for (int s = 0; s < 2; s++) run_scan(mask_of(4'hB), 1'b0, "roll_b");
    for (int s = 0; s < 2; s++) run_scan(mask_of(4'hC), 1'b0, "roll_c");
    run_scan(mask_of(4'hC), 1'b1, "roll_drain");
    for (int s = 0; s < 2; s++) run_scan(16'h0, 1'b0, "roll_rel");
    for (int s = 0; s < 2; s++) run_scan(mask_of(4'hD), 1'b0, "roll_d");
    check("pre_rst_valid", key_valid, 1'b1);
    @(posedge clk);
    #1;
    do_reset("mid_rst");
    run_scan(16'h0, 1'b0, "post_rst");

    // Randomized key activity with random consumer readiness.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        rm = 16'h0;
      end else if (kind < 8) begin
        rm = 16'h0;
        rm[$urandom_range(0, 15)] = 1'b1;
      end else begin
        a  = $urandom_range(0, 15);
        b  = (a + 1 + $urandom_range(0, 14)) % 16;
        rm = 16'h0;
        rm[a] = 1'b1;
        rm[b] = 1'b1;
      end
      hold = $urandom_range(1, 3);
      for (int s = 0; s < hold; s++)
        run_scan(rm, ($urandom_range(0, 3) == 0), "rand");
    end
    for (int s = 0; s < 2; s++) run_scan(16'h0, 1'b1, "rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
